rom_byte_streamer: RTL and testbench

Sequencer that owns the word-addressed instruction ROM's address port and streams a programmed range of words out as individual bytes over a valid/ready interface. Each 32-bit word is split little-endian: bits 7:0 go to the lowest byte address. The block sits between the ROM and any byte-oriented consumer, such as a memory dump/checker, a serial loader or a byte-wide bus bridge. It also reports the 10-bit byte address of every byte it emits.

---
 rtl/rom_byte_streamer_if.sv | 23 ++
 rtl/rom_byte_streamer.sv | 90 +++++++++
 tb/tb_rom_byte_streamer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rom_byte_streamer_if.sv
// rom_byte_streamer_if: valid/ready byte stream carrying data and its byte address
interface rom_byte_streamer_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  byte_valid;
    logic                  byte_ready;
    logic [7:0]            byte_data;
    logic [ADDR_WIDTH+1:0] byte_addr;

    modport master (
        output byte_valid,
        output byte_data,
        output byte_addr,
        input  byte_ready
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        input  byte_addr,
        output byte_ready
    );
endinterface

// File: rtl/rom_byte_streamer.sv
// rom_byte_streamer: walks a word range of the ROM and emits it little-endian byte by byte
module rom_byte_streamer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_word,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  busy,
    output logic                  done,
    rom_byte_streamer_if.master   bs
);
    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] REM_FULL = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] cur_word, cur_n;
    logic [ADDR_WIDTH:0]   remaining, rem_n;
    logic [1:0]            idx, idx_n;
    logic [DATA_WIDTH-1:0] word_buf, buf_n;
    logic                  send, hs;

    assign send          = state == SEND;
    assign hs            = send & bs.byte_ready;
    assign busy          = state != IDLE;
    assign done          = state == DONE;
    assign rom_addr      = cur_word;
    assign bs.byte_valid = send;
    assign bs.byte_data  = send ? word_buf[{idx, 3'b000} +: 8] : 8'h00;
    assign bs.byte_addr  = send ? {cur_word, idx} : '0;

    // State and datapath registers; outputs fall to reset values as soon as rst_n drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_word  <= '0;
            remaining <= '0;
            idx       <= '0;
            word_buf  <= '0;
        end else begin
            state     <= state_n;
            cur_word  <= cur_n;
            remaining <= rem_n;
            idx       <= idx_n;
            word_buf  <= buf_n;
        end
    end

    // Next-state logic; abort freezes the datapath so a byte accepted in that cycle is discarded
    always_comb begin
        state_n = state;
        cur_n   = cur_word;
        rem_n   = remaining;
        idx_n   = idx;
        buf_n   = word_buf;
        case (state)
            IDLE: if (start) begin
                cur_n   = start_word;
                rem_n   = word_count == '0 ? REM_FULL : word_count;
                state_n = FETCH;
            end
            FETCH: begin
                buf_n   = rom_data;
                idx_n   = 2'd0;
                state_n = SEND;
            end
            SEND: if (hs) begin
                idx_n = idx + 2'd1;
                if (idx == 2'd3) begin
                    rem_n   = remaining - (ADDR_WIDTH+1)'(1);
                    cur_n   = cur_word + ADDR_WIDTH'(1);
                    state_n = rem_n == '0 ? DONE : FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_n = IDLE;
            cur_n   = cur_word;
            rem_n   = remaining;
            idx_n   = idx;
        end
    end
endmodule

// File: tb/tb_rom_byte_streamer.sv
// tb_rom_byte_streamer: randomized and directed byte-stream checks against an address-based reference
module tb_rom_byte_streamer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] start_word = '0;
    logic [8:0] word_count = '0;
    logic       abort = 1'b0;
    logic [7:0] rom_addr;
    logic [31:0] rom_data;
    logic       busy, done;
    int         checks = 0;
    int         errors = 0;

    rom_byte_streamer_if #(.ADDR_WIDTH(8)) bs_if ();

    rom_byte_streamer #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_word(start_word),
        .word_count(word_count), .abort(abort), .rom_addr(rom_addr),
        .rom_data(rom_data), .busy(busy), .done(done), .bs(bs_if)
    );

    always #5 clk = ~clk;

    // ROM word w holds bytes {w, w+1, w+2, w+3} from byte 3 down to byte 0
    assign rom_data = {rom_addr, rom_addr + 8'd1, rom_addr + 8'd2, rom_addr + 8'd3};

    function automatic int exp_byte(input int a);
        return ((a / 4) + 3 - (a % 4)) % 256;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int s, input int n, input bit rnd, input int abort_at, input bit glitch);
        int nw = (n == 0) ? 256 : n;
        int hs = 0;
        int cyc = 0;
        int a;
        bit stall = 1'b0;
        bit fin = 1'b0;
        logic [7:0] pd = '0;
        logic [9:0] pa = '0;
        start_word = 8'(s);
        word_count = 9'(n);
        start = 1'b1;
        step();
        start = 1'b0;
        while (!fin && cyc < 40 * nw + 20) begin
            bs_if.byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (glitch && cyc == 3) begin
                start = 1'b1;
                start_word = 8'(s + 7);
                word_count = 9'd1;
            end else start = 1'b0;
            if (bs_if.byte_valid) begin
                if (stall) begin
                    chk("hold_data", 32'(bs_if.byte_data), 32'(pd));
                    chk("hold_addr", 32'(bs_if.byte_addr), 32'(pa));
                end
                if (abort_at == hs) abort = 1'b1;
                else if (bs_if.byte_ready) begin
                    a = (4 * s + hs) % 1024;
                    chk("byte_addr", 32'(bs_if.byte_addr), 32'(a));
                    chk("byte_data", 32'(bs_if.byte_data), 32'(exp_byte(a)));
                    hs++;
                end
                stall = !bs_if.byte_ready;
                pd = bs_if.byte_data;
                pa = bs_if.byte_addr;
            end else stall = 1'b0;
            if (done) begin
                chk("handshakes", 32'(hs), 32'(4 * nw));
                if (!rnd) chk("done_latency", 32'(cyc), 32'(5 * nw));
                fin = 1'b1;
            end
            step();
            cyc++;
            if (abort) begin
                abort = 1'b0;
                chk("abort_valid", 32'(bs_if.byte_valid), 32'(0));
                chk("abort_busy", 32'(busy), 32'(0));
                chk("abort_done", 32'(done), 32'(0));
                start = 1'b0;
                return;
            end
        end
        start = 1'b0;
        chk("finished", 32'(fin), 32'(1));
        chk("end_busy", 32'(busy), 32'(0));
        chk("end_done", 32'(done), 32'(0));
        chk("end_rom_addr", 32'(rom_addr), 32'((s + nw) % 256));
    endtask

    initial begin
        bs_if.byte_ready = 1'b1;
        step();
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_valid", 32'(bs_if.byte_valid), 32'(0));
        chk("rst_data", 32'(bs_if.byte_data), 32'(0));
        chk("rst_addr", 32'(bs_if.byte_addr), 32'(0));
        chk("rst_rom_addr", 32'(rom_addr), 32'(0));
        rst_n = 1'b1;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 32'(0));

        run(8'h10, 2, 1'b0, -1, 1'b0);
        run(8'hFF, 2, 1'b0, -1, 1'b0);
        run(0, 0, 1'b0, -1, 1'b0);
        for (int i = 0; i < 6; i++)
            run(int'($urandom_range(0, 255)), int'($urandom_range(1, 4)), 1'b1, -1, 1'b0);
        run(8'h30, 3, 1'b1, -1, 1'b1);

        run(8'h20, 3, 1'b0, 6, 1'b0);
        run(8'h40, 1, 1'b0, -1, 1'b0);

        start_word = 8'h05;
        word_count = 9'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre_rst_valid", 32'(bs_if.byte_valid), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'(0));
        chk("async_valid", 32'(bs_if.byte_valid), 32'(0));
        chk("async_data", 32'(bs_if.byte_data), 32'(0));
        chk("async_addr", 32'(bs_if.byte_addr), 32'(0));
        chk("async_rom_addr", 32'(rom_addr), 32'(0));
        step();
        rst_n = 1'b1;
        step();
        run(8'h80, 2, 1'b1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
